// File: rtl/massbus_test_drive_if.sv
// Massbus signal bundle between an RH11-style controller (master) and one drive (slave).
// Data buses use Massbus bit numbering [0:35], where bit 0 is the MSB.
//   master: drives strobes, function, ack and write data; receives request, data, status.
//   slave : the drive side; the mirror image of master.
interface massbus_test_drive_if;
    logic        mbINIT;
    logic        mbREAD;
    logic        mbWRITE;
    logic [4:0]  mbREGSEL;
    logic [2:0]  mbUNIT;
    logic [4:0]  mbFUN;
    logic        mbGO;
    logic        mbWCZ;
    logic        mbPAT;
    logic        mbACKI;
    logic [0:35] mbDATAI;
    logic [0:35] mbDATAO;
    logic        mbREQO;
    logic [15:0] mbREGDAT;
    logic        mbREGACK;
    logic        mbINCBA;
    logic        mbINCWC;
    logic        mbDECBA;
    logic        mbWCE;
    logic        mbACLO;
    logic        mbINVPAR;
    logic        mbNPRO;
    logic [7:0]  mbATA;
    logic        mbDVA;
    logic        mbDPR;
    logic        mbDRY;

    modport master (
        output mbINIT, mbREAD, mbWRITE, mbREGSEL, mbUNIT, mbFUN, mbGO, mbWCZ, mbPAT, mbACKI,
               mbDATAI,
        input  mbDATAO, mbREQO, mbREGDAT, mbREGACK, mbINCBA, mbINCWC, mbDECBA, mbWCE, mbACLO,
               mbINVPAR, mbNPRO, mbATA, mbDVA, mbDPR, mbDRY
    );

    modport slave (
        input  mbINIT, mbREAD, mbWRITE, mbREGSEL, mbUNIT, mbFUN, mbGO, mbWCZ, mbPAT, mbACKI,
               mbDATAI,
        output mbDATAO, mbREQO, mbREGDAT, mbREGACK, mbINCBA, mbINCWC, mbDECBA, mbWCE, mbACLO,
               mbINVPAR, mbNPRO, mbATA, mbDVA, mbDPR, mbDRY
    );
endinterface

// File: rtl/massbus_test_drive.sv
// Stand-in Massbus drive for one unit: answers register reads/writes and runs read-data /
// write-data functions through the mbREQO/mbACKI word handshake. Read data is SEED + WCNT,
// write data is summed into a 36-bit checksum.
//   clk : clock
//   rst : synchronous reset, active low
//   mb  : Massbus bundle, slave side (see massbus_test_drive_if)
module massbus_test_drive #(
    parameter logic [2:0]  UNIT  = 3'd0,
    parameter logic [15:0] DTYPE = 16'o020022
) (
    input logic                 clk,
    input logic                 rst,
    massbus_test_drive_if.slave mb
);
    localparam logic [4:0] FunRead  = 5'o34;
    localparam logic [4:0] FunWrite = 5'o30;

    typedef enum logic [2:0] {StIdle, StRdReq, StWrReq, StGap, StDone} state_t;

    state_t      state;
    logic [4:0]  fun;
    logic        err;
    logic        ata;
    logic [15:0] wcnt;
    logic [15:0] seed;
    logic [0:35] cksum;
    logic        lastWcz;
    logic        regAck;
    logic [15:0] regDat;

    logic        unitHit;
    logic        goHit;
    logic        dry;
    logic [15:0] readMux;
    logic [7:0]  ataVec;

    assign unitHit = (mb.mbUNIT == UNIT);
    assign goHit   = mb.mbGO && unitHit;
    assign dry     = (state == StIdle);

    always_comb begin
        readMux = '0;
        case (mb.mbREGSEL)
            5'd0: readMux = {4'b0, 1'b1, 3'b0, dry, 1'b0, fun, 1'b0};
            5'd1: readMux = {ata, err, 5'b0, 1'b1, dry, 7'b0};
            5'd2: readMux = wcnt;
            5'd3: readMux = cksum[20:35];
            5'd4: readMux = cksum[4:19];
            5'd5: readMux = {12'b0, cksum[0:3]};
            5'd6: readMux = seed;
            5'd7: readMux = DTYPE;
            default: readMux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // mbINIT is an abort with the same effect as reset and wins over any other event.
        if (!rst || mb.mbINIT) begin
            state   <= StIdle;
            fun     <= '0;
            err     <= 1'b0;
            ata     <= 1'b0;
            wcnt    <= '0;
            seed    <= '0;
            cksum   <= '0;
            lastWcz <= 1'b0;
            regAck  <= 1'b0;
            regDat  <= '0;
        end else begin
            regAck <= 1'b0;
            regDat <= '0;
            // Read and write strobes together still give a single ack.
            if ((mb.mbREAD || mb.mbWRITE) && unitHit) begin
                regAck <= 1'b1;
                regDat <= readMux;
            end

            case (state)
                StIdle: begin
                    if (goHit) begin
                        fun <= mb.mbFUN;
                        if (mb.mbFUN == FunRead) begin
                            state <= StRdReq;
                        end else if (mb.mbFUN == FunWrite) begin
                            state <= StWrReq;
                            cksum <= '0;
                        end else begin
                            ata <= 1'b1;
                        end
                    end
                end
                StRdReq, StWrReq: begin
                    if (mb.mbACKI) begin
                        if (state == StWrReq) cksum <= cksum + mb.mbDATAI;
                        wcnt    <= wcnt + 16'd1;
                        lastWcz <= mb.mbWCZ;
                        state   <= StGap;
                    end
                end
                StGap: begin
                    if (lastWcz)              state <= StDone;
                    else if (fun == FunRead)  state <= StRdReq;
                    else                      state <= StWrReq;
                end
                StDone: begin
                    ata   <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase

            // A GO while busy is flagged but does not disturb the running transfer.
            if (goHit && state != StIdle) begin
                err <= 1'b1;
                ata <= 1'b1;
            end

            // Register writes are applied last so they take precedence over FSM updates.
            if (mb.mbWRITE && unitHit) begin
                case (mb.mbREGSEL)
                    5'd1: if (mb.mbDATAI[20]) begin
                        ata <= 1'b0;
                        err <= 1'b0;
                    end
                    5'd2: wcnt <= mb.mbDATAI[20:35];
                    5'd6: seed <= mb.mbDATAI[20:35];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ataVec       = '0;
        ataVec[UNIT] = ata;
    end

    assign mb.mbREQO    = (state == StRdReq) || (state == StWrReq);
    assign mb.mbDATAO   = (state == StRdReq) ? (36'(seed) + 36'(wcnt)) : '0;
    assign mb.mbINCBA   = (state == StGap);
    assign mb.mbINCWC   = (state == StGap);
    assign mb.mbNPRO    = mb.mbREQO || (state == StGap);
    assign mb.mbDRY     = dry;
    assign mb.mbDVA     = 1'b1;
    assign mb.mbDPR     = 1'b1;
    assign mb.mbDECBA   = 1'b0;
    assign mb.mbWCE     = 1'b0;
    assign mb.mbACLO    = 1'b0;
    assign mb.mbINVPAR  = mb.mbPAT;
    assign mb.mbATA     = ataVec;
    assign mb.mbREGACK  = regAck;
    assign mb.mbREGDAT  = regDat;
endmodule

// File: tb/tb_massbus_test_drive.sv
// Directed bench for massbus_test_drive: register access, read and write transfers,
// stall, busy GO, and aborts by mbINIT and by reset.
module tb_massbus_test_drive;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   incCount = 0;

    massbus_test_drive_if mb();

    massbus_test_drive #(
        .UNIT  (3'd0),
        .DTYPE (16'o020022)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mb  (mb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic regRead(input logic [4:0] sel, input logic [15:0] exp, input string tag);
        mb.mbREGSEL = sel;
        mb.mbREAD   = 1'b1;
        tick();
        mb.mbREAD   = 1'b0;
        chk({tag, "_ack"}, 36'(mb.mbREGACK), 36'd1);
        chk(tag, 36'(mb.mbREGDAT), 36'(exp));
    endtask

    task automatic regWrite(input logic [4:0] sel, input logic [15:0] val);
        mb.mbREGSEL = sel;
        mb.mbDATAI  = 36'(val);
        mb.mbWRITE  = 1'b1;
        tick();
        mb.mbWRITE  = 1'b0;
        mb.mbDATAI  = '0;
    endtask

    task automatic go(input logic [4:0] f);
        mb.mbFUN = f;
        mb.mbGO  = 1'b1;
        tick();
        mb.mbGO  = 1'b0;
    endtask

    // One acknowledged word: ack cycle followed by the GAP cycle.
    task automatic ackWord(input logic [35:0] data, input logic wcz, input string tag);
        mb.mbDATAI = data;
        mb.mbACKI  = 1'b1;
        mb.mbWCZ   = wcz;
        tick();
        mb.mbACKI  = 1'b0;
        mb.mbWCZ   = 1'b0;
        mb.mbDATAI = '0;
        chk({tag, "_gap_reqo"}, 36'(mb.mbREQO), 36'd0);
        chk({tag, "_incba"}, 36'(mb.mbINCBA), 36'd1);
        chk({tag, "_incwc"}, 36'(mb.mbINCWC), 36'd1);
        if (mb.mbINCBA === 1'b1) incCount++;
        tick();
    endtask

    initial begin
        mb.mbINIT = 0; mb.mbREAD = 0; mb.mbWRITE = 0; mb.mbREGSEL = 0; mb.mbUNIT = 0;
        mb.mbFUN = 0; mb.mbGO = 0; mb.mbWCZ = 0; mb.mbPAT = 0; mb.mbACKI = 0; mb.mbDATAI = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_reqo", 36'(mb.mbREQO), 36'd0);
        chk("rst_dry", 36'(mb.mbDRY), 36'd1);
        chk("rst_dva", 36'(mb.mbDVA), 36'd1);
        chk("rst_dpr", 36'(mb.mbDPR), 36'd1);
        chk("rst_regack", 36'(mb.mbREGACK), 36'd0);
        chk("rst_npro", 36'(mb.mbNPRO), 36'd0);
        chk("rst_ata", 36'(mb.mbATA), 36'd0);
        rst = 1'b1;
        tick();

        // Register reads
        regRead(5'd7, 16'o020022, "dtype");
        tick();
        chk("ack_pulse_end", 36'(mb.mbREGACK), 36'd0);
        chk("regdat_idle", 36'(mb.mbREGDAT), 36'd0);
        regRead(5'd0, 16'o004200, "cs_reset");
        regRead(5'd9, 16'h0000, "reg9");
        mb.mbPAT = 1'b1;
        #1 chk("invpar", 36'(mb.mbINVPAR), 36'd1);
        mb.mbPAT = 1'b0;

        // Read transfer of four words
        regWrite(5'd6, 16'h0100);
        go(5'o34);
        chk("rd_reqo", 36'(mb.mbREQO), 36'd1);
        chk("rd_npro", 36'(mb.mbNPRO), 36'd1);
        chk("rd_dry", 36'(mb.mbDRY), 36'd0);
        chk("rd_incba_req", 36'(mb.mbINCBA), 36'd0);
        for (int k = 0; k < 4; k++) begin
            chk("rd_data", mb.mbDATAO, 36'h100 + 36'(k));
            ackWord('0, k == 3, "rd");
        end
        chk("rd_done_dry", 36'(mb.mbDRY), 36'd0);
        chk("rd_done_reqo", 36'(mb.mbREQO), 36'd0);
        tick();
        chk("rd_idle_dry", 36'(mb.mbDRY), 36'd1);
        chk("rd_inc_count", 36'(incCount), 36'd4);
        chk("rd_ata_out", 36'(mb.mbATA), 36'h01);
        regRead(5'd2, 16'd4, "rd_wcnt");
        regRead(5'd1, 16'h8180, "rd_ds");

        // Write transfer: checksum wraps mod 2^36
        regWrite(5'd1, 16'h8000);
        regRead(5'd1, 16'h0180, "ds_clr");
        go(5'o30);
        chk("wr_reqo", 36'(mb.mbREQO), 36'd1);
        chk("wr_datao_zero", mb.mbDATAO, 36'd0);
        ackWord(36'h0_0000_0001, 1'b0, "wr1");
        ackWord(36'hF_FFFF_FFFF, 1'b0, "wr2");
        ackWord(36'h0_0000_0001, 1'b1, "wr3");
        tick();
        chk("wr_idle_dry", 36'(mb.mbDRY), 36'd1);
        regRead(5'd3, 16'd1, "cksum_lo");
        regRead(5'd4, 16'd0, "cksum_mid");
        regRead(5'd5, 16'd0, "cksum_hi");
        regRead(5'd1, 16'h8180, "wr_ds");
        regRead(5'd0, 16'h08B0, "cs_fun30");

        // Clear ATA, unknown function, unit mismatch, dual strobe
        regWrite(5'd1, 16'h8000);
        regRead(5'd1, 16'h0180, "ds_clr2");
        go(5'o01);
        chk("badfun_dry", 36'(mb.mbDRY), 36'd1);
        chk("badfun_ata", 36'(mb.mbATA), 36'h01);
        regWrite(5'd1, 16'h8000);
        mb.mbUNIT = 3'd3;
        mb.mbREGSEL = 5'd7;
        mb.mbREAD = 1'b1;
        tick();
        mb.mbREAD = 1'b0;
        chk("unit3_noack", 36'(mb.mbREGACK), 36'd0);
        tick();
        chk("unit3_noack2", 36'(mb.mbREGACK), 36'd0);
        mb.mbUNIT = 3'd0;
        mb.mbREGSEL = 5'd6;
        mb.mbDATAI = 36'h5;
        mb.mbREAD = 1'b1;
        mb.mbWRITE = 1'b1;
        tick();
        mb.mbREAD = 1'b0;
        mb.mbWRITE = 1'b0;
        mb.mbDATAI = '0;
        chk("dual_ack", 36'(mb.mbREGACK), 36'd1);
        tick();
        chk("dual_single", 36'(mb.mbREGACK), 36'd0);
        regRead(5'd6, 16'h0005, "dual_seed");

        // Stall and busy GO
        regWrite(5'd2, 16'd0);
        go(5'o34);
        chk("st_data0", mb.mbDATAO, 36'd5);
        ackWord('0, 1'b0, "st");
        for (int i = 0; i < 10; i++) begin
            chk("stall_reqo", 36'(mb.mbREQO), 36'd1);
            chk("stall_data", mb.mbDATAO, 36'd6);
            tick();
        end
        go(5'o34);
        chk("busygo_reqo", 36'(mb.mbREQO), 36'd1);
        chk("busygo_data", mb.mbDATAO, 36'd6);
        regRead(5'd1, 16'hC100, "busy_ds");
        ackWord('0, 1'b1, "st_last");
        tick();
        chk("st_idle", 36'(mb.mbDRY), 36'd1);
        regRead(5'd2, 16'd2, "st_wcnt");

        // mbINIT coincident with ack mid-read
        regWrite(5'd1, 16'h8000);
        go(5'o34);
        chk("in_data0", mb.mbDATAO, 36'd7);
        ackWord('0, 1'b0, "in");
        mb.mbACKI = 1'b1;
        mb.mbINIT = 1'b1;
        tick();
        mb.mbACKI = 1'b0;
        mb.mbINIT = 1'b0;
        chk("init_reqo", 36'(mb.mbREQO), 36'd0);
        chk("init_incba", 36'(mb.mbINCBA), 36'd0);
        chk("init_dry", 36'(mb.mbDRY), 36'd1);
        chk("init_npro", 36'(mb.mbNPRO), 36'd0);
        regRead(5'd2, 16'd0, "init_wcnt");
        regRead(5'd6, 16'd0, "init_seed");

        // Reset coincident with ack mid-read
        regWrite(5'd2, 16'd3);
        go(5'o34);
        chk("rs_reqo_pre", 36'(mb.mbREQO), 36'd1);
        mb.mbACKI = 1'b1;
        rst = 1'b0;
        tick();
        mb.mbACKI = 1'b0;
        rst = 1'b1;
        chk("rst2_reqo", 36'(mb.mbREQO), 36'd0);
        chk("rst2_incba", 36'(mb.mbINCBA), 36'd0);
        chk("rst2_dry", 36'(mb.mbDRY), 36'd1);
        regRead(5'd2, 16'd0, "rst2_wcnt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
